// File: rtl/gyro_pkg.sv
// Shared gyro-path types and default constants (also used by GyroTilt/GyroFsm).
package gyro_pkg;

  localparam int unsigned GYRO_CAL_SAMPLES_LOG2 = 6;
  localparam int unsigned GYRO_DEADBAND         = 8;

  typedef logic signed [15:0] gyro_sample_t;

  typedef enum logic {
    CAL = 1'b0,
    RUN = 1'b1
  } cal_state_t;

endpackage

// File: rtl/gyro_bias_cal_axis_corr.sv
// One-axis bias correction: subtract, saturate to W bits, apply deadband.
// Also reports the deadband ("still") flag and the sign of the raw difference.
module gyro_axis_corr
  import gyro_pkg::*;
#(
  parameter int unsigned W        = 16,
  parameter int unsigned DEADBAND = GYRO_DEADBAND
) (
  input  logic signed [W-1:0] raw_i,
  input  logic signed [W-1:0] bias_i,
  output logic signed [W-1:0] corr_o,
  output logic                still_o,
  output logic                diff_pos_o,
  output logic                diff_neg_o
);

  localparam logic signed [W:0] DB_POS = (W+1)'(DEADBAND);
  localparam logic signed [W:0] DB_NEG = -DB_POS;

  logic signed [W:0]   diff;
  logic signed [W-1:0] sat;

  always_comb begin
    diff = (W+1)'(raw_i) - (W+1)'(bias_i);

    // Top two bits disagree only when the difference left the W-bit range.
    if (diff[W] != diff[W-1]) begin
      sat = diff[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      sat = diff[W-1:0];
    end

    // Deadband far smaller than the W-bit range, so the unsaturated diff suffices.
    still_o    = (diff >= DB_NEG) && (diff <= DB_POS);
    corr_o     = still_o ? '0 : sat;
    diff_neg_o = diff[W];
    diff_pos_o = !diff[W] && (diff != '0);
  end

endmodule

// File: rtl/gyro_bias_cal.sv
// Gyro zero-rate bias calibration and correction (CAL/RUN FSM).
// Optional slow bias tracking while still: define GYRO_BIAS_TRACK_EN.
module gyro_bias_cal
  import gyro_pkg::*;
#(
  parameter int unsigned CAL_SAMPLES_LOG2 = GYRO_CAL_SAMPLES_LOG2,
  parameter int unsigned DEADBAND         = GYRO_DEADBAND,
  parameter int unsigned W                = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic signed [W-1:0] raw_x,
  input  logic signed [W-1:0] raw_y,
  input  logic signed [W-1:0] raw_z,
  input  logic                raw_valid,
  input  logic                recal,
  output logic signed [W-1:0] dx,
  output logic signed [W-1:0] dy,
  output logic signed [W-1:0] dz,
  output logic                out_valid,
  output logic                cal_done,
  output logic signed [W-1:0] bias_x,
  output logic signed [W-1:0] bias_y,
  output logic signed [W-1:0] bias_z
);

  localparam int unsigned ACC_W = W + CAL_SAMPLES_LOG2;
  localparam int unsigned CNT_W = CAL_SAMPLES_LOG2;

  cal_state_t                state_q, state_d;
  logic        [CNT_W-1:0]   cnt_q, cnt_d;
  logic signed [ACC_W-1:0]   acc_x_q, acc_y_q, acc_z_q;
  logic signed [ACC_W-1:0]   acc_x_d, acc_y_d, acc_z_d;
  logic signed [W-1:0]       bias_x_q, bias_y_q, bias_z_q;
  logic signed [W-1:0]       bias_x_d, bias_y_d, bias_z_d;
  logic signed [W-1:0]       dx_q, dy_q, dz_q;
  logic signed [W-1:0]       dx_d, dy_d, dz_d;
  logic                      out_valid_q, out_valid_d;

  logic signed [ACC_W-1:0]   sum_x, sum_y, sum_z;
  logic signed [ACC_W-1:0]   avg_x, avg_y, avg_z;

  logic signed [W-1:0]       corr_x, corr_y, corr_z;
  logic                      still_x, still_y, still_z;
  logic                      pos_x, pos_y, pos_z;
  logic                      neg_x, neg_y, neg_z;

  gyro_axis_corr #(.W(W), .DEADBAND(DEADBAND)) u_corr_x (
    .raw_i(raw_x), .bias_i(bias_x_q), .corr_o(corr_x),
    .still_o(still_x), .diff_pos_o(pos_x), .diff_neg_o(neg_x)
  );
  gyro_axis_corr #(.W(W), .DEADBAND(DEADBAND)) u_corr_y (
    .raw_i(raw_y), .bias_i(bias_y_q), .corr_o(corr_y),
    .still_o(still_y), .diff_pos_o(pos_y), .diff_neg_o(neg_y)
  );
  gyro_axis_corr #(.W(W), .DEADBAND(DEADBAND)) u_corr_z (
    .raw_i(raw_z), .bias_i(bias_z_q), .corr_o(corr_z),
    .still_o(still_z), .diff_pos_o(pos_z), .diff_neg_o(neg_z)
  );

`ifndef GYRO_BIAS_TRACK_EN
  logic unused_track;
  assign unused_track = ^{still_x, still_y, still_z, pos_x, pos_y, pos_z, neg_x, neg_y, neg_z};
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_x_d     = acc_x_q;
    acc_y_d     = acc_y_q;
    acc_z_d     = acc_z_q;
    bias_x_d    = bias_x_q;
    bias_y_d    = bias_y_q;
    bias_z_d    = bias_z_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    dz_d        = dz_q;
    out_valid_d = 1'b0;

    sum_x = acc_x_q + ACC_W'(raw_x);
    sum_y = acc_y_q + ACC_W'(raw_y);
    sum_z = acc_z_q + ACC_W'(raw_z);
    // Arithmetic shift floors toward -inf.
    avg_x = sum_x >>> CAL_SAMPLES_LOG2;
    avg_y = sum_y >>> CAL_SAMPLES_LOG2;
    avg_z = sum_z >>> CAL_SAMPLES_LOG2;

    unique case (state_q)
      CAL: begin
        if (recal) begin
          cnt_d   = '0;
          acc_x_d = '0;
          acc_y_d = '0;
          acc_z_d = '0;
        end else if (raw_valid) begin
          if (cnt_q == '1) begin
            bias_x_d = avg_x[W-1:0];
            bias_y_d = avg_y[W-1:0];
            bias_z_d = avg_z[W-1:0];
            cnt_d    = '0;
            acc_x_d  = '0;
            acc_y_d  = '0;
            acc_z_d  = '0;
            state_d  = RUN;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            acc_x_d = sum_x;
            acc_y_d = sum_y;
            acc_z_d = sum_z;
          end
        end
      end

      RUN: begin
        if (recal) begin
          state_d = CAL;
          cnt_d   = '0;
          acc_x_d = '0;
          acc_y_d = '0;
          acc_z_d = '0;
        end else if (raw_valid) begin
          dx_d        = corr_x;
          dy_d        = corr_y;
          dz_d        = corr_z;
          out_valid_d = 1'b1;
`ifdef GYRO_BIAS_TRACK_EN
          // Nudge each bias one LSB toward raw only when all axes are still.
          if (still_x && still_y && still_z) begin
            if (pos_x) bias_x_d = bias_x_q + W'(1);
            else if (neg_x) bias_x_d = bias_x_q - W'(1);
            if (pos_y) bias_y_d = bias_y_q + W'(1);
            else if (neg_y) bias_y_d = bias_y_q - W'(1);
            if (pos_z) bias_z_d = bias_z_q + W'(1);
            else if (neg_z) bias_z_d = bias_z_q - W'(1);
          end
`endif
        end
      end

      default: state_d = CAL;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= CAL;
      cnt_q       <= '0;
      acc_x_q     <= '0;
      acc_y_q     <= '0;
      acc_z_q     <= '0;
      bias_x_q    <= '0;
      bias_y_q    <= '0;
      bias_z_q    <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      dz_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_x_q     <= acc_x_d;
      acc_y_q     <= acc_y_d;
      acc_z_q     <= acc_z_d;
      bias_x_q    <= bias_x_d;
      bias_y_q    <= bias_y_d;
      bias_z_q    <= bias_z_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      dz_q        <= dz_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign dx        = dx_q;
  assign dy        = dy_q;
  assign dz        = dz_q;
  assign out_valid = out_valid_q;
  assign cal_done  = (state_q == RUN);
  assign bias_x    = bias_x_q;
  assign bias_y    = bias_y_q;
  assign bias_z    = bias_z_q;

endmodule

// File: tb/tb_gyro_bias_cal.sv
// Directed self-checking bench for gyro_bias_cal with hand-computed expectations.
module tb_gyro_bias_cal;

  logic               CLK = 1'b0;
  logic               RST;
  logic signed [15:0] raw_x, raw_y, raw_z;
  logic               raw_valid, recal;
  logic signed [15:0] dx, dy, dz;
  logic               out_valid, cal_done;
  logic signed [15:0] bias_x, bias_y, bias_z;

  int vectors = 0;
  int miscompares = 0;

  gyro_bias_cal #(.CAL_SAMPLES_LOG2(6), .DEADBAND(8), .W(16)) dut (
    .CLK(CLK), .RST(RST),
    .raw_x(raw_x), .raw_y(raw_y), .raw_z(raw_z),
    .raw_valid(raw_valid), .recal(recal),
    .dx(dx), .dy(dy), .dz(dz),
    .out_valid(out_valid), .cal_done(cal_done),
    .bias_x(bias_x), .bias_y(bias_y), .bias_z(bias_z)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are read there too.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input int x, input int y, input int z);
    raw_x = 16'(x); raw_y = 16'(y); raw_z = 16'(z);
    raw_valid = 1'b1;
    tick();
    raw_valid = 1'b0;
  endtask

  task automatic pulse_recal(input logic with_sample);
    recal = 1'b1;
    raw_valid = with_sample;
    raw_x = 16'sd5000; raw_y = 16'sd5000; raw_z = 16'sd5000;
    tick();
    recal = 1'b0;
    raw_valid = 1'b0;
  endtask

  task automatic calibrate(input string tag, input int xa, input int xb, input int y, input int z);
    logic ov_seen;
    ov_seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      send((i % 2 == 0) ? xa : xb, y, z);
      ov_seen |= out_valid;
      if (i == 62) check({tag, " cal_done@63"}, int'(cal_done), 0);
    end
    check({tag, " cal_done@64"}, int'(cal_done), 1);
    check({tag, " out_valid in CAL"}, int'(ov_seen), 0);
  endtask

  initial begin
    RST = 1'b1; recal = 1'b0; raw_valid = 1'b0;
    raw_x = '0; raw_y = '0; raw_z = '0;
    tick(); tick();
    RST = 1'b0;
    check("rst dx", int'(dx), 0);
    check("rst bias_x", int'(bias_x), 0);
    check("rst out_valid", int'(out_valid), 0);
    check("rst cal_done", int'(cal_done), 0);

    calibrate("cal1", 100, 100, -50, 0);
    check("cal1 bias_x", int'(bias_x), 100);
    check("cal1 bias_y", int'(bias_y), -50);
    check("cal1 bias_z", int'(bias_z), 0);

    // Back-to-back samples, none of them still.
    send(1100, -50, 0);
    check("run dx 1100", int'(dx), 1000);
    check("run ov", int'(out_valid), 1);
    send(109, -50, 0);
    check("run dx 109", int'(dx), 9);
    check("run ov b2b", int'(out_valid), 1);
    send(100, -59, 0);
    check("run dy -59", int'(dy), -9);
    check("run dx 100", int'(dx), 0);
    send(105, -50, 0);
    check("run dx 105 deadband", int'(dx), 0);
    tick();
    check("run ov idle", int'(out_valid), 0);

    pulse_recal(1'b1);
    check("recal ov", int'(out_valid), 0);
    check("recal cal_done", int'(cal_done), 0);
    check("recal bias_y held", int'(bias_y), -50);
    check("recal dy held", int'(dy), 0);
    calibrate("floor", -3, -4, 0, 0);
    check("floor bias_x", int'(bias_x), -4);

    // Recal in CAL restarts from zero: junk samples must not count.
    pulse_recal(1'b0);
    for (int i = 0; i < 10; i++) send(9999, 0, 0);
    pulse_recal(1'b0);
    calibrate("neg1000", -1000, -1000, 0, 0);
    check("neg1000 bias_x", int'(bias_x), -1000);
    send(32767, 0, 0);
    check("sat pos dx", int'(dx), 32767);

    pulse_recal(1'b0);
    calibrate("pos1000", 1000, 1000, 0, 0);
    send(-32768, 0, 0);
    check("sat neg dx", int'(dx), -32768);

    pulse_recal(1'b0);
    for (int i = 0; i < 30; i++) send(500, 500, 500);
    RST = 1'b1;
    raw_valid = 1'b1; raw_x = 16'sd500;
    tick();
    RST = 1'b0; raw_valid = 1'b0;
    check("midrst dx", int'(dx), 0);
    check("midrst bias_x", int'(bias_x), 0);
    check("midrst cal_done", int'(cal_done), 0);
    calibrate("postrst", 7, 7, 7, 7);
    check("postrst bias_x", int'(bias_x), 7);

    pulse_recal(1'b0);
    calibrate("trk", 100, 100, -50, 0);
`ifdef GYRO_BIAS_TRACK_EN
    send(103, -50, 0);
    check("trk bias_x 1", int'(bias_x), 101);
    send(103, -50, 0);
    send(103, -50, 0);
    check("trk bias_x 3", int'(bias_x), 103);
    check("trk dx", int'(dx), 0);
    send(200, -50, 0);
    check("trk bias_x move", int'(bias_x), 103);
    check("trk dx move", int'(dx), 97);
`else
    send(103, -50, 0);
    send(103, -50, 0);
    send(103, -50, 0);
    check("frozen bias_x", int'(bias_x), 100);
    send(200, -50, 0);
    check("frozen dx", int'(dx), 100);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gyro_bias_cal.md
Name: gyro_bias_cal

Overview:
Sits between GyroFsm and GyroTilt on the gyro path. At start-up, and on request, it averages a block of still-state raw angular-velocity samples to find each axis's zero-rate bias. It then subtracts that bias from every later sample, saturates the result, and applies a deadband. The output is the corrected dx/dy/dz that GyroTilt integrates, so zero-rate offset no longer causes tilt drift.

Parameters:
CAL_SAMPLES_LOG2, 6, log2 of the number of samples averaged per calibration (default 64).
DEADBAND, 8, corrected magnitudes <= this value are forced to 0 (raw LSB units).
W, 16, sample width, signed two's complement.

Ports:
CLK  in  1  system clock; all logic is on posedge.
RST  in  1  synchronous, active-high reset.
raw_x, raw_y, raw_z  in  W each  signed raw angular velocity from GyroFsm.
raw_valid  in  1  one-cycle strobe; raw_x/y/z are valid in that cycle.
recal  in  1  one-cycle request to discard the bias and recalibrate.
dx, dy, dz  out  W each  signed corrected angular velocity to GyroTilt.
out_valid  out  1  one-cycle strobe; dx/dy/dz are updated in that cycle.
cal_done  out  1  high while in RUN (bias valid).
bias_x, bias_y, bias_z  out  W each  current bias, for debug/display.

Behaviour:
- Reset (RST=1 at posedge):
  - state=CAL; sample counter=0; accumulators=0.
  - dx/dy/dz=0, bias_*=0, out_valid=0, cal_done=0.
  - Reset overrides every other input in that cycle, including mid-calibration.
- States: CAL, RUN (2-state FSM).
- CAL:
  - Each raw_valid adds the sign-extended sample to a per-axis accumulator of W+CAL_SAMPLES_LOG2 bits; counter increments.
  - On the raw_valid with counter = 2^CAL_SAMPLES_LOG2-1:
    - bias_* = (acc + sample) >>> CAL_SAMPLES_LOG2, arithmetic shift, so the result floors toward -inf.
    - Counter and accumulators clear; state goes to RUN; cal_done rises in the next cycle.
  - out_valid stays 0 throughout CAL; dx/dy/dz hold their last value.
- RUN, on raw_valid (per axis):
  - diff = raw - bias, computed in W+1 bits.
  - Saturate diff to [-2^(W-1), 2^(W-1)-1].
  - If |sat| <= DEADBAND the output is 0; otherwise it is sat.
  - dx/dy/dz are registered and out_valid pulses in the cycle after raw_valid (latency 1).
  - Back-to-back raw_valid gives back-to-back out_valid.
- recal:
  - In RUN: next state=CAL, counter/accumulators cleared, cal_done=0, bias_* held until the new calibration finishes.
  - In CAL: calibration restarts from 0.
  - recal has priority over a simultaneous raw_valid; that sample is dropped and is not counted.
  - out_valid is never asserted in the cycle after a recal.
- No backpressure exists; the downstream stage must accept every out_valid pulse.

Optional Feature:
GYRO_BIAS_TRACK_EN
- Defined: in RUN, for any raw_valid where all three axes fall inside the deadband (the "still" condition), each bias_* moves 1 LSB toward raw (+1 if diff>0, -1 if diff<0, unchanged if 0). The update takes effect in the same cycle as out_valid, so bias slowly follows temperature drift.
- Undefined: bias_* is frozen between calibrations; no tracking logic is synthesised.

Decomposition:
- Package gyro_pkg:
  - typedef gyro_sample_t (logic signed [15:0]).
  - enum cal_state_t {CAL, RUN}.
  - Default constants GYRO_CAL_SAMPLES_LOG2=6 and GYRO_DEADBAND=8, shared with GyroTilt/GyroFsm.
- Sub-module gyro_axis_corr: purely combinational subtract / saturate / deadband for one axis, instantiated 3x.
- The FSM, counter, accumulators and output registers stay in gyro_bias_cal.

Test Plan:
- 64 raw_valid with x=100, y=-50, z=0 -> bias=(100,-50,0); cal_done=1 one cycle after the 64th strobe; no out_valid during CAL.
- After that calibration: raw x=1100 -> dx=1000 one cycle later; raw x=105 -> dx=0 (deadband); raw x=109 -> dx=9; raw y=-59 -> dy=-9.
- Calibrate x with alternating -3/-4 (sum -224) -> bias_x=-4 (floor). Calibrate x=-1000, then raw x=32767 -> dx=32767 (saturated); calibrate x=1000, then raw x=-32768 -> dx=-32768.
- In RUN, assert recal together with raw_valid -> no out_valid, cal_done=0, old bias held; the next 64 samples produce the new bias.
- Assert RST after 30 calibration samples -> all outputs 0 and state CAL; 64 further samples are required before cal_done.
- With GYRO_BIAS_TRACK_EN and bias_x=100: raw (103,-50,0) x3 -> bias_x=103; raw x=200 -> bias unchanged.
